// File: rtl/qpsk_mod_pkg.sv
// Shared defaults, FSM encoding and the quarter-wave sine table for the QPSK modulator.
package qpsk_mod_pkg;

    localparam int PHASE_BITS_DEF     = 6;
    localparam int AMP_BITS_DEF       = 8;
    localparam int SYMBOL_PERIODS_DEF = 2;

    localparam int QTR_ENTRIES  = 17;
    localparam int QTR_AMP_BITS = 7;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Entry i = round(127*sin(pi/2*i/16)), entry 0 in the least significant slot.
    localparam logic [QTR_ENTRIES-1:0][QTR_AMP_BITS-1:0] QTR_SIN = {
        7'd127, 7'd126, 7'd125, 7'd122, 7'd117, 7'd112, 7'd106, 7'd98, 7'd90,
        7'd81,  7'd71,  7'd60,  7'd49,  7'd37,  7'd25,  7'd12,  7'd0
    };

    function automatic logic [QTR_AMP_BITS-1:0] qtr_sin(input logic [4:0] idx);
        return (idx > 5'd16) ? QTR_SIN[16] : QTR_SIN[idx];
    endfunction

endpackage

// File: rtl/qpsk_sin_lut.sv
// Registered sine lookup: quarter-wave table with mirroring and negation from the top phase bits.
module qpsk_sin_lut
    import qpsk_mod_pkg::*;
#(
    parameter int PHASE_BITS = PHASE_BITS_DEF,
    parameter int AMP_BITS   = AMP_BITS_DEF
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [PHASE_BITS-1:0]      phase,
    output logic signed [AMP_BITS-1:0] value
);

    localparam int QB = PHASE_BITS - 2;
    localparam logic [QB:0] QTR_END = {1'b1, {QB{1'b0}}};

    logic [1:0]                 quad;
    logic [QB-1:0]              off;
    logic [QB:0]                idx;
    logic signed [AMP_BITS-1:0] mag;
    logic signed [AMP_BITS-1:0] value_next;

    // Odd quadrants read the table backwards; the lower half-cycle is negated.
    always_comb begin
        quad       = phase[PHASE_BITS-1 -: 2];
        off        = phase[QB-1:0];
        idx        = quad[0] ? (QTR_END - {1'b0, off}) : {1'b0, off};
        mag        = {{(AMP_BITS-QTR_AMP_BITS){1'b0}}, qtr_sin(idx)};
        value_next = quad[1] ? -mag : mag;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            value <= '0;
        end else if (enable) begin
            value <= value_next;
        end
    end

endmodule

// File: rtl/qpsk_mod.sv
// QPSK modulator: one-entry symbol buffer and IDLE/RUN sequencer driving a
// phase -> LUT -> sum pipeline that produces sample = (+/-cos) + (+/-sin).
module qpsk_mod
    import qpsk_mod_pkg::*;
#(
    parameter int PHASE_BITS     = PHASE_BITS_DEF,
    parameter int AMP_BITS       = AMP_BITS_DEF,
    parameter int SYMBOL_PERIODS = SYMBOL_PERIODS_DEF
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [1:0]               symbol_in,
    input  logic                     symbol_valid,
    output logic                     symbol_ready,
    output logic signed [AMP_BITS:0] sample,
    output logic                     sample_valid,
    output logic                     underrun
);

    localparam int PER_W = (SYMBOL_PERIODS > 1) ? $clog2(SYMBOL_PERIODS) : 1;
    localparam logic [PER_W-1:0]      PER_LAST   = PER_W'(SYMBOL_PERIODS - 1);
    localparam logic [PHASE_BITS-1:0] PHASE_LAST = '1;
    localparam logic [PHASE_BITS-1:0] PHASE_QTR  = {2'b01, {(PHASE_BITS-2){1'b0}}};

    state_t                     state;
    logic [PHASE_BITS-1:0]      phase_p0;
    logic [PHASE_BITS-1:0]      cos_phase_p0;
    logic [PER_W-1:0]           period_cnt;
    logic [1:0]                 current_p0;
    logic [1:0]                 next_sym;
    logic                       next_full;
    logic                       xfer;
    logic                       boundary;
    logic                       vld_p0;
    logic signed [AMP_BITS-1:0] sin_p1;
    logic signed [AMP_BITS-1:0] cos_p1;
    logic [1:0]                 sym_p1;
    logic                       vld_p1;

    function automatic logic signed [AMP_BITS:0] qpsk_combine(
        input logic signed [AMP_BITS-1:0] cos_v,
        input logic signed [AMP_BITS-1:0] sin_v,
        input logic [1:0]                 sym
    );
        logic signed [AMP_BITS:0] i_term;
        logic signed [AMP_BITS:0] q_term;
        i_term = {cos_v[AMP_BITS-1], cos_v};
        q_term = {sin_v[AMP_BITS-1], sin_v};
        if (sym[0]) i_term = -i_term;
        if (sym[1]) q_term = -q_term;
        return i_term + q_term;
    endfunction

    assign symbol_ready = !next_full;
    assign xfer         = symbol_valid && symbol_ready;
    assign boundary     = (state == ST_RUN) && enable && (phase_p0 == PHASE_LAST)
                          && (period_cnt == PER_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            phase_p0   <= '0;
            period_cnt <= '0;
            current_p0 <= '0;
            next_sym   <= '0;
            next_full  <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            underrun <= 1'b0;
            if (xfer && !boundary) begin
                next_sym  <= symbol_in;
                next_full <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (enable && next_full) begin
                        state      <= ST_RUN;
                        current_p0 <= next_sym;
                        next_full  <= 1'b0;
                        phase_p0   <= '0;
                        period_cnt <= '0;
                    end
                end
                ST_RUN: begin
                    if (enable) begin
                        phase_p0 <= phase_p0 + PHASE_BITS'(1);
                        if (phase_p0 == PHASE_LAST) begin
                            period_cnt <= (period_cnt == PER_LAST) ? '0 : period_cnt + PER_W'(1);
                        end
                        // Symbol boundary: buffered symbol first, then a same-cycle bypass, else stop.
                        if (boundary) begin
                            if (next_full) begin
                                current_p0 <= next_sym;
                                next_full  <= 1'b0;
                            end else if (xfer) begin
                                current_p0 <= symbol_in;
                            end else begin
                                underrun <= 1'b1;
                                state    <= ST_IDLE;
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // ---- stage p0 -> p1: quarter-wave lookups, symbol and qualifier follow the phase
    assign vld_p0       = (state == ST_RUN) && enable;
    assign cos_phase_p0 = phase_p0 + PHASE_QTR;

    qpsk_sin_lut #(
        .PHASE_BITS (PHASE_BITS),
        .AMP_BITS   (AMP_BITS)
    ) u_sin_lut (
        .clock  (clock),
        .reset  (reset),
        .enable (enable),
        .phase  (phase_p0),
        .value  (sin_p1)
    );

    qpsk_sin_lut #(
        .PHASE_BITS (PHASE_BITS),
        .AMP_BITS   (AMP_BITS)
    ) u_cos_lut (
        .clock  (clock),
        .reset  (reset),
        .enable (enable),
        .phase  (cos_phase_p0),
        .value  (cos_p1)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sym_p1 <= '0;
            vld_p1 <= 1'b0;
        end else if (enable) begin
            sym_p1 <= current_p0;
            vld_p1 <= vld_p0;
        end
    end

    // ---- stage p1 -> p2: signed sum; output is forced to zero whenever it is not valid
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sample       <= '0;
            sample_valid <= 1'b0;
        end else if (enable && vld_p1) begin
            sample       <= qpsk_combine(cos_p1, sin_p1, sym_p1);
            sample_valid <= 1'b1;
        end else begin
            sample       <= '0;
            sample_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_qpsk_mod.sv
// Directed bench for qpsk_mod with a sample scoreboard fed from a real-valued sine/cosine model.
module tb_qpsk_mod;

    localparam int  AW  = 8;
    localparam int  SPS = 128;
    localparam real PI  = 3.14159265358979323846;

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 enable;
    logic [1:0]           symbol_in;
    logic                 symbol_valid;
    logic                 symbol_ready;
    logic signed [AW:0]   sample;
    logic                 sample_valid;
    logic                 underrun;

    int total = 0;
    int bad   = 0;

    logic signed [AW:0] sb [$];
    logic signed [AW:0] exp_s;

    logic               win_v [0:511];
    logic               win_u [0:511];
    logic               win_r [0:511];
    logic signed [AW:0] win_s [0:511];
    int fv, lv, nv, fu, nu;

    qpsk_mod #(
        .PHASE_BITS     (6),
        .AMP_BITS       (AW),
        .SYMBOL_PERIODS (2)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .symbol_in    (symbol_in),
        .symbol_valid (symbol_valid),
        .symbol_ready (symbol_ready),
        .sample       (sample),
        .sample_valid (sample_valid),
        .underrun     (underrun)
    );

    always #5 clock = ~clock;

    function automatic int rnd127(input real x);
        real y;
        y = 127.0 * x;
        return (y >= 0.0) ? $rtoi(y + 0.5) : -$rtoi(-y + 0.5);
    endfunction

    function automatic logic signed [AW:0] ref_sample(input int p, input logic [1:0] s);
        real th;
        int  c, sn, v;
        th = 2.0 * PI * real'(p) / 64.0;
        c  = rnd127($cos(th));
        sn = rnd127($sin(th));
        v  = (s[0] ? -c : c) + (s[1] ? -sn : sn);
        return (AW+1)'(v);
    endfunction

    task automatic push_symbol(input logic [1:0] s);
        for (int k = 0; k < SPS; k++) sb.push_back(ref_sample(k % 64, s));
    endtask

    task automatic chk(input string tag, input int obs, input int expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic send(input logic [1:0] s);
        int n;
        n = 0;
        while (!symbol_ready && n < 1000) begin
            @(negedge clock);
            n++;
        end
        chk("send_ready_wait", int'(symbol_ready), 1);
        symbol_in    = s;
        symbol_valid = 1'b1;
        push_symbol(s);
        @(negedge clock);
        symbol_valid = 1'b0;
    endtask

    // Records n cycles of outputs; optionally offers a symbol after cycle drv_at and
    // drops enable for pause_len cycles starting after cycle pause_at.
    task automatic run_window(input int n, input int drv_at, input logic [1:0] drv_sym,
                              input int pause_at, input int pause_len);
        fv = -1; lv = -1; nv = 0; fu = -1; nu = 0;
        for (int i = 1; i <= n; i++) begin
            @(negedge clock);
            win_v[i] = sample_valid;
            win_u[i] = underrun;
            win_r[i] = symbol_ready;
            win_s[i] = sample;
            if (sample_valid) begin
                if (fv < 0) fv = i;
                lv = i;
                nv++;
            end
            if (underrun) begin
                if (fu < 0) fu = i;
                nu++;
            end
            symbol_valid = 1'b0;
            if (i == drv_at) begin
                symbol_in    = drv_sym;
                symbol_valid = 1'b1;
                push_symbol(drv_sym);
            end
            enable = !(i >= pause_at && i < pause_at + pause_len);
        end
        symbol_valid = 1'b0;
        enable       = 1'b1;
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (sample_valid) begin
                total++;
                assert (sb.size() > 0) else begin
                    bad++;
                    $error("FAIL sb_extra observed=%0d expected=no sample", sample);
                end
                if (sb.size() > 0) begin
                    exp_s = sb.pop_front();
                    total++;
                    assert (sample === exp_s) else begin
                        bad++;
                        $error("FAIL sb_sample observed=%0d expected=%0d", sample, exp_s);
                    end
                end
            end else begin
                total++;
                assert (sample === '0) else begin
                    bad++;
                    $error("FAIL idle_zero observed=%0d expected=0", sample);
                end
            end
        end
    end

    initial begin
        reset        = 1'b1;
        enable       = 1'b0;
        symbol_valid = 1'b0;
        symbol_in    = 2'b00;
        @(negedge clock);
        chk("rst_sample",   int'(sample), 0);
        chk("rst_valid",    int'(sample_valid), 0);
        chk("rst_underrun", int'(underrun), 0);
        chk("rst_ready",    int'(symbol_ready), 1);
        reset  = 1'b0;
        enable = 1'b1;

        // Single symbol 00, then underrun and drain
        send(2'b00);
        run_window(140, -1, 2'b00, -1, 0);
        chk("t1_latency",  fv, 3);
        chk("t1_phase0",   int'(win_s[3]), 127);
        chk("t1_phase8",   int'(win_s[11]), 180);
        chk("t1_count",    nv, 128);
        chk("t1_last",     lv, 130);
        chk("t1_ur_at",    fu, 129);
        chk("t1_ur_cnt",   nu, 1);
        chk("t1_ready_ur", int'(win_r[129]), 1);
        chk("t1_drain",    int'(win_v[130]), 1);
        chk("t1_drop",     int'(win_v[131]), 0);
        chk("t1_sb_empty", sb.size(), 0);

        // Back-to-back symbols 11 then 01
        send(2'b11);
        send(2'b01);
        run_window(270, -1, 2'b00, -1, 0);
        chk("t2_first",    fv, 1);
        chk("t2_count",    nv, 256);
        chk("t2_no_gap",   lv - fv + 1, 256);
        chk("t2_s11_p0",   int'(win_s[1]), -127);
        chk("t2_s11_p16",  int'(win_s[17]), -127);
        chk("t2_s01_p0",   int'(win_s[129]), -127);
        chk("t2_s01_p16",  int'(win_s[145]), 127);
        chk("t2_ur_cnt",   nu, 1);
        chk("t2_ur_at",    fu, 255);
        chk("t2_sb_empty", sb.size(), 0);

        // Transfer lands exactly on the boundary with the buffer empty
        send(2'b10);
        run_window(280, 128, 2'b01, -1, 0);
        chk("t3_first",    fv, 3);
        chk("t3_count",    nv, 256);
        chk("t3_last",     lv, 258);
        chk("t3_ur_cnt",   nu, 1);
        chk("t3_ur_at",    fu, 257);
        chk("t3_no_ur_b",  int'(win_u[129]), 0);
        chk("t3_old_p63",  int'(win_s[130]), int'(ref_sample(63, 2'b10)));
        chk("t3_new_p0",   int'(win_s[131]), int'(ref_sample(0, 2'b01)));
        chk("t3_sb_empty", sb.size(), 0);

        // Enable dropped for 10 cycles while phase is 20
        send(2'b10);
        run_window(160, -1, 2'b00, 21, 10);
        chk("t4_first",    fv, 3);
        chk("t4_count",    nv, 128);
        chk("t4_last",     lv, 140);
        chk("t4_holes",    lv - fv + 1 - nv, 10);
        chk("t4_pre",      int'(win_v[21]), 1);
        chk("t4_hold_v",   int'(win_v[22]), 0);
        chk("t4_hold_s",   int'(win_s[22]), 0);
        chk("t4_hold_end", int'(win_v[31]), 0);
        chk("t4_resume",   int'(win_v[32]), 1);
        chk("t4_resume_s", int'(win_s[32]), int'(ref_sample(19, 2'b10)));
        chk("t4_ur_at",    fu, 139);
        chk("t4_ur_cnt",   nu, 1);
        chk("t4_sb_empty", sb.size(), 0);

        // Asynchronous reset at phase 40 with a second symbol buffered
        send(2'b11);
        send(2'b01);
        repeat (39) @(negedge clock);
        chk("t5_pre_valid", int'(sample_valid), 1);
        #2;
        reset = 1'b1;
        sb.delete();
        #1;
        chk("t5_async_sample", int'(sample), 0);
        chk("t5_async_valid",  int'(sample_valid), 0);
        chk("t5_async_ready",  int'(symbol_ready), 1);
        chk("t5_async_ur",     int'(underrun), 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        run_window(20, -1, 2'b00, -1, 0);
        chk("t5_quiet_valid", nv, 0);
        chk("t5_quiet_ur",    nu, 0);
        chk("t5_quiet_ready", int'(win_r[20]), 1);
        send(2'b00);
        run_window(140, -1, 2'b00, -1, 0);
        chk("t5_new_first",  fv, 3);
        chk("t5_new_p0",     int'(win_s[3]), 127);
        chk("t5_new_count",  nv, 128);
        chk("t5_sb_empty",   sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
